ex_wb_forward: RTL and testbench
================================

# ex_wb_forward

Writeback stage and forwarding source for the 4-stage pipeline (IF, ID, EX, WB). It registers the EX-stage ALU result into the WB pipeline register and commits it to the 8-entry register file. It drives the `forward_a` / `forward_sel` pair that the ALU consumes as its operand-A bypass. It also serves the ID-stage register reads, with write-through bypass, and counts committed writes.

## Interface
- `DATA_W`, 8, datapath width
- `REG_CNT`, 8, number of architectural registers
- `ADDR_W`, 3, register address width; REG_CNT = 2**ADDR_W
- `clk`  in  1  single clock; all state updates on the rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `ex_valid`  in  1  an instruction occupies EX this cycle
- `ex_we`  in  1  the EX instruction writes a register
- `ex_rd`  in  ADDR_W  EX destination register
- `ex_result`  in  DATA_W  ALU result
- `ex_rs1`  in  ADDR_W  operand-A source register of the EX instruction
- `flush`  in  1  kill the EX instruction (branch or redirect)
- `id_rs1`, `id_rs2`  in  ADDR_W  ID-stage read addresses
- `rs1_data`, `rs2_data`  out  DATA_W  ID-stage read data
- `forward_sel`  out  1  ALU must use `forward_a` instead of A
- `forward_a`  out  DATA_W  forwarded operand-A value
- `wb_valid`  out  1  WB register holds a committing write
- `wb_rd`  out  ADDR_W  WB destination
- `wb_data`  out  DATA_W  WB data
- `commit_cnt`  out  16  number of register writes committed

## Operation
- **WB capture** (each rising edge):
  - `wb_valid` <= ex_valid & ex_we & ~flush & (ex_rd != 0)
  - `wb_rd` <= ex_rd
  - `wb_data` <= ex_result
  - `wb_rd` and `wb_data` load unconditionally; they are meaningful only while `wb_valid` = 1.
- **r0:**
  - r0 is hardwired to zero.
  - Writes to r0 never set `wb_valid`.
  - Reads of r0 return 0.
  - r0 is never forwarded.
- **Commit** (rising edge while `wb_valid` = 1):
  - regfile[wb_rd] <= wb_data
  - `commit_cnt` increments by 1 and wraps from 0xFFFF to 0x0000.
- **Forwarding** (combinational):
  - `forward_sel` = wb_valid & (wb_rd == ex_rs1)
  - `forward_a` = wb_data, driven regardless of `forward_sel`
- **ID read** (combinational, each port independent):
  - If the address is 0, data = 0.
  - Else if wb_valid & (wb_rd == addr), data = wb_data (write-through).
  - Else data = regfile[addr].
- **flush:**
  - Suppresses capture of the current EX instruction only.
  - An already-valid WB entry still commits, and forwarding from it is unaffected.
- **Width:** all data is DATA_W and unsigned. No extension or truncation is performed.

## Timing
- **Reset** (`rst_n` low, asynchronous, held while low):
  - `wb_valid` = 0, `wb_rd` = 0, `wb_data` = 0, `commit_cnt` = 0, all registers = 0.
  - Consequently `forward_sel` = 0, `forward_a` = 0, `rs1_data` = `rs2_data` = 0.
- **Reset mid-operation:** an in-flight WB entry is discarded and never committed. The first capture is at the first rising edge after `rst_n` deasserts.
- **Latency:**
  - A result in EX during cycle N is in WB during cycle N+1.
  - It is forwardable to the EX instruction of cycle N+1.
  - It is readable in ID during cycle N+1 via write-through.
  - It is in the array from cycle N+2 onward.
- **Back-to-back writes to the same register:** the newer write occupies WB and wins both forwarding and read bypass. The older write is already in the array.
- **Simultaneous commit and read of the same register:** the bypass returns the new value, never the stale one.
- There is no stall or back-pressure; the block accepts one instruction per cycle.
- Outputs `wb_*` and `commit_cnt` are registered. `rs*_data`, `forward_*` are combinational from registered state and inputs.

## Test plan
- **Reset:** assert `rst_n` = 0 mid-stream with `wb_valid` = 1 (r3 <- 0x55).
  - Required: all outputs 0 immediately, without waiting for a clock edge.
  - Required: after release, r3 reads 0x00 and `commit_cnt` = 0.
- **Basic commit:** EX writes r2 <- 0x3C in cycle 0.
  - Cycle 1: `wb_valid` = 1, `wb_rd` = 2, `wb_data` = 0x3C, and `rs1_data` = 0x3C with `id_rs1` = 2 (bypass).
  - Cycle 2: `rs1_data` = 0x3C from the array, `commit_cnt` = 1.
- **Forward:** cycle 0 writes r5 <- 0xA0; cycle 1 EX has `ex_rs1` = 5.
  - Required: `forward_sel` = 1, `forward_a` = 0xA0.
  - With `ex_rs1` = 4 instead: `forward_sel` = 0.
- **r0 and flush:**
  - EX writes r0 <- 0xFF. Required: `wb_valid` = 0, `forward_sel` = 0 with `ex_rs1` = 0, and r0 reads 0.
  - EX writes r1 <- 0x11 with `flush` = 1. Required: r1 is unchanged and `commit_cnt` is unchanged.
- **Back-to-back:** r6 <- 0x01 then r6 <- 0x02 on consecutive cycles.
  - Required: in the cycle the second write is in WB, `forward_a` = 0x02 and `rs2_data` = 0x02 with `id_rs2` = 6.
  - Required: finally r6 = 0x02 and `commit_cnt` has advanced by 2.
- **Counter wrap:** preload `commit_cnt` to 0xFFFF via 65535 commits, then issue 1 more commit.
  - Required: `commit_cnt` = 0x0000.

Source files
------------

// File: rtl/ex_wb_forward.sv
// ex_wb_forward
// Writeback stage of the 4-stage pipeline. It registers the EX result into the
// WB pipeline register and commits it to the register file on the next edge.
// It supplies the operand-A bypass to the ALU and serves the two ID-stage
// read ports with write-through from the WB register. It also counts
// committed writes.
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   ex_valid, ex_we       EX instruction present / writes a register
//   ex_rd, ex_result      EX destination and ALU result
//   ex_rs1                EX operand-A source (forward compare)
//   flush                 kill the EX instruction
//   id_rs1, id_rs2        ID read addresses
//   rs1_data, rs2_data    ID read data (combinational, bypassed)
//   forward_sel/forward_a operand-A bypass to the ALU
//   wb_valid/wb_rd/wb_data WB pipeline register
//   commit_cnt            committed-write counter (wraps)
module ex_wb_forward #(
    parameter int DATA_W  = 8,
    parameter int REG_CNT = 8,
    parameter int ADDR_W  = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ex_valid,
    input  logic              ex_we,
    input  logic [ADDR_W-1:0] ex_rd,
    input  logic [DATA_W-1:0] ex_result,
    input  logic [ADDR_W-1:0] ex_rs1,
    input  logic              flush,
    input  logic [ADDR_W-1:0] id_rs1,
    input  logic [ADDR_W-1:0] id_rs2,
    output logic [DATA_W-1:0] rs1_data,
    output logic [DATA_W-1:0] rs2_data,
    output logic              forward_sel,
    output logic [DATA_W-1:0] forward_a,
    output logic              wb_valid,
    output logic [ADDR_W-1:0] wb_rd,
    output logic [DATA_W-1:0] wb_data,
    output logic [15:0]       commit_cnt
);

    logic [DATA_W-1:0] regs [REG_CNT];
    logic              capture;

    // A write to r0 is dropped here, so r0 never enters WB and is never
    // committed, forwarded or bypassed.
    assign capture = ex_valid & ex_we & ~flush & (ex_rd != '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wb_valid   <= 1'b0;
            wb_rd      <= '0;
            wb_data    <= '0;
            commit_cnt <= '0;
            for (int i = 0; i < REG_CNT; i++) begin
                regs[i] <= '0;
            end
        end else begin
            wb_valid <= capture;
            wb_rd    <= ex_rd;
            wb_data  <= ex_result;
            if (wb_valid) begin
                regs[wb_rd] <= wb_data;
                commit_cnt  <= commit_cnt + 16'd1;
            end
        end
    end

    assign forward_sel = wb_valid & (wb_rd == ex_rs1);
    assign forward_a   = wb_data;

    // Write-through: the entry committing this cycle is returned instead of
    // the stale array value.
    function automatic logic [DATA_W-1:0] read_port(input logic [ADDR_W-1:0] addr);
        if (addr == '0)
            return '0;
        else if (wb_valid && (wb_rd == addr))
            return wb_data;
        else
            return regs[addr];
    endfunction

    always_comb begin
        rs1_data = read_port(id_rs1);
        rs2_data = read_port(id_rs2);
    end

endmodule

// File: tb/tb_ex_wb_forward.sv
module tb_ex_wb_forward;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       ex_valid, ex_we, flush;
    logic [2:0] ex_rd, ex_rs1, id_rs1, id_rs2;
    logic [7:0] ex_result;
    logic [7:0] rs1_data, rs2_data, forward_a, wb_data;
    logic       forward_sel, wb_valid;
    logic [2:0] wb_rd;
    logic [15:0] commit_cnt;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    ex_wb_forward dut (
        .clk(clk), .rst_n(rst_n),
        .ex_valid(ex_valid), .ex_we(ex_we), .ex_rd(ex_rd), .ex_result(ex_result),
        .ex_rs1(ex_rs1), .flush(flush), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .rs1_data(rs1_data), .rs2_data(rs2_data),
        .forward_sel(forward_sel), .forward_a(forward_a),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
        .commit_cnt(commit_cnt)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [2:0] rd, input logic [7:0] val, input logic fl);
        ex_valid  = 1'b1;
        ex_we     = 1'b1;
        ex_rd     = rd;
        ex_result = val;
        flush     = fl;
    endtask

    task automatic idle();
        ex_valid = 1'b0;
        ex_we    = 1'b0;
        flush    = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        idle();
        ex_rd = 0; ex_result = 0; ex_rs1 = 0; id_rs1 = 0; id_rs2 = 0;
        tick(); tick();
        check("rst_wb_valid", wb_valid, 0);
        check("rst_cnt", commit_cnt, 0);
        rst_n = 1'b1;
        tick();

        // reset with an in-flight WB entry r3 <- 0x55
        issue(3'd3, 8'h55, 1'b0);
        tick();
        idle();
        id_rs1 = 3'd3;
        #1;
        check("pre_rst_wb_valid", wb_valid, 1);
        check("pre_rst_rs1", rs1_data, 8'h55);
        #1 rst_n = 1'b0;
        #1;
        check("async_wb_valid", wb_valid, 0);
        check("async_wb_rd", wb_rd, 0);
        check("async_wb_data", wb_data, 0);
        check("async_fwd_a", forward_a, 0);
        check("async_fwd_sel", forward_sel, 0);
        check("async_rs1", rs1_data, 0);
        check("async_cnt", commit_cnt, 0);
        rst_n = 1'b1;
        tick(); tick();
        check("post_rst_r3", rs1_data, 8'h00);
        check("post_rst_cnt", commit_cnt, 0);

        // basic commit r2 <- 0x3C
        issue(3'd2, 8'h3C, 1'b0);
        id_rs1 = 3'd2;
        tick();
        idle();
        #1;
        check("basic_wb_valid", wb_valid, 1);
        check("basic_wb_rd", wb_rd, 2);
        check("basic_wb_data", wb_data, 8'h3C);
        check("basic_bypass", rs1_data, 8'h3C);
        tick();
        check("basic_wb_clear", wb_valid, 0);
        check("basic_array", rs1_data, 8'h3C);
        check("basic_cnt", commit_cnt, 1);

        // forwarding r5 <- 0xA0
        issue(3'd5, 8'hA0, 1'b0);
        tick();
        idle();
        ex_rs1 = 3'd5;
        #1;
        check("fwd_sel", forward_sel, 1);
        check("fwd_a", forward_a, 8'hA0);
        ex_rs1 = 3'd4;
        #1;
        check("fwd_sel_miss", forward_sel, 0);
        tick();
        check("fwd_cnt", commit_cnt, 2);

        // r0 write is discarded
        issue(3'd0, 8'hFF, 1'b0);
        tick();
        idle();
        ex_rs1 = 3'd0; id_rs1 = 3'd0;
        #1;
        check("r0_wb_valid", wb_valid, 0);
        check("r0_fwd_sel", forward_sel, 0);
        check("r0_read", rs1_data, 0);

        // flushed write r1 <- 0x11
        issue(3'd1, 8'h11, 1'b1);
        tick();
        idle();
        #1;
        check("flush_wb_valid", wb_valid, 0);
        tick();
        id_rs1 = 3'd1;
        #1;
        check("flush_r1", rs1_data, 0);
        check("flush_cnt", commit_cnt, 2);

        // back-to-back r6 <- 0x01, r6 <- 0x02
        issue(3'd6, 8'h01, 1'b0);
        tick();
        issue(3'd6, 8'h02, 1'b0);
        tick();
        idle();
        ex_rs1 = 3'd6; id_rs2 = 3'd6;
        #1;
        check("b2b_fwd_sel", forward_sel, 1);
        check("b2b_fwd_a", forward_a, 8'h02);
        check("b2b_rs2", rs2_data, 8'h02);
        tick();
        check("b2b_array", rs2_data, 8'h02);
        check("b2b_cnt", commit_cnt, 4);

        // counter wrap: 65531 more commits reach 0xFFFF, then one more wraps
        ex_valid = 1'b1; ex_we = 1'b1; ex_rd = 3'd7; flush = 1'b0;
        for (int i = 0; i < 65531; i++) begin
            ex_result = 8'(i);
            tick();
        end
        idle();
        tick();
        check("cnt_ffff", commit_cnt, 16'hFFFF);
        issue(3'd7, 8'h9A, 1'b0);
        tick();
        idle();
        tick();
        id_rs1 = 3'd7; id_rs2 = 3'd2;
        #1;
        check("cnt_wrap", commit_cnt, 16'h0000);
        check("wrap_r7", rs1_data, 8'h9A);
        check("keep_r2", rs2_data, 8'h3C);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
